// File: rtl/two_sum_scheduler_if.sv
// Requester-fabric and response-channel bundle for two_sum_scheduler.
//   req_number/req_target : per-requester number and target, slot i at [i*DW +: DW]
//   req_valid/req_last    : per-requester number valid and end-of-frame flag
//   req_ready             : per-requester number accepted (valid & ready)
//   resp_valid/resp_ready : response handshake
//   resp_id/resp_found/resp_index1/resp_index2 : response payload
// master = requester side, slave = scheduler side.
interface two_sum_scheduler_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 2,
    parameter int ARRAY_SIZE = 2**DATA_WIDTH
);
    localparam int IDX_W = $clog2(ARRAY_SIZE);
    localparam int ID_W  = $clog2(NUM_REQ);

    logic [NUM_REQ*DATA_WIDTH-1:0] req_number;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_target;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [ID_W-1:0]               resp_id;
    logic                          resp_found;
    logic [IDX_W-1:0]              resp_index1;
    logic [IDX_W-1:0]              resp_index2;

    modport master (
        output req_number, req_target, req_valid, req_last, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_found, resp_index1, resp_index2
    );

    modport slave (
        input  req_number, req_target, req_valid, req_last, resp_ready,
        output req_ready, resp_valid, resp_id, resp_found, resp_index1, resp_index2
    );
endinterface

// File: rtl/two_sum_scheduler.sv
// Round-robin scheduler sharing one streaming two-sum engine between NUM_REQ
// requesters. A granted frame is forwarded unchanged to the engine (truncated
// to ARRAY_SIZE numbers, the remainder is swallowed), the first result the
// engine reports is captured and handed back to the frame owner.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : requester numbers/targets and response channel
//   eng_number/_valid/_last, eng_target : frame towards the engine
//   eng_clear         : one-cycle engine purge on leaving DRAIN
//   eng_index1/2/_valid : result from the engine
//   busy              : scheduler not idle
module two_sum_scheduler #(
    parameter int  NUM_REQ    = 2,
    parameter int  DATA_WIDTH = 2,
    parameter int  ARRAY_SIZE = 2**DATA_WIDTH,
    localparam int IDX_W      = $clog2(ARRAY_SIZE),
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    two_sum_scheduler_if.slave     bus,
    output logic [DATA_WIDTH-1:0]  eng_number,
    output logic                   eng_number_valid,
    output logic                   eng_number_last,
    output logic [DATA_WIDTH-1:0]  eng_target,
    output logic                   eng_clear,
    input  logic [IDX_W-1:0]       eng_index1,
    input  logic [IDX_W-1:0]       eng_index2,
    input  logic                   eng_index_valid,
    output logic                   busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [ID_W-1:0]         rr_r;
    logic [ID_W-1:0]         grant_r;
    logic [ID_W-1:0]         grant_s;
    logic                    grant_hit_s;
    logic [DATA_WIDTH-1:0]   target_r;
    logic [IDX_W-1:0]        cnt_r;
    logic                    found_r;
    logic [IDX_W-1:0]        idx1_r;
    logic [IDX_W-1:0]        idx2_r;
    logic [NUM_REQ-1:0]      req_ready_s;
    logic                    eng_valid_s;
    logic                    eng_last_s;
    logic                    eng_clear_s;
    logic                    g_valid_s;
    logic                    g_last_s;
    logic [DATA_WIDTH-1:0]   g_number_s;
    logic                    cnt_max_s;

    // Granted requester's slot, selected from the latched grant.
    assign g_valid_s  = bus.req_valid[grant_r];
    assign g_last_s   = bus.req_last[grant_r];
    assign g_number_s = bus.req_number[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
    assign cnt_max_s  = (cnt_r == IDX_W'(ARRAY_SIZE-1));

    // Round-robin search: first requesting slot at or after the rr pointer.
    always_comb begin : arb
        logic [ID_W-1:0] slot_v;
        grant_hit_s = 1'b0;
        grant_s     = '0;
        slot_v      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot_v = ID_W'((int'(rr_r) + k) % NUM_REQ);
            if (!grant_hit_s && bus.req_valid[slot_v]) begin
                grant_hit_s = 1'b1;
                grant_s     = slot_v;
            end else begin
                grant_hit_s = grant_hit_s;
            end
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_s     = state_r;
        req_ready_s = '0;
        eng_valid_s = 1'b0;
        eng_last_s  = 1'b0;
        eng_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_hit_s) begin
                    state_s = ST_STREAM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                req_ready_s[grant_r] = 1'b1;
                eng_valid_s          = g_valid_s;
                // The engine sees a last on the ARRAY_SIZE-th number even if
                // the requester has more; the rest is swallowed in FLUSH.
                eng_last_s           = g_last_s | cnt_max_s;
                if (g_valid_s && g_last_s) begin
                    state_s = ST_DRAIN;
                end else if (g_valid_s && cnt_max_s) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                req_ready_s[grant_r] = 1'b1;
                if (g_valid_s && g_last_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                // One cycle for the engine's result on the final number;
                // the clear lands on the same edge that leaves DRAIN.
                eng_clear_s = 1'b1;
                state_s     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, target latch, frame counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r     <= '0;
            grant_r  <= '0;
            target_r <= '0;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_hit_s) begin
                        grant_r  <= grant_s;
                        target_r <= bus.req_target[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];
                        cnt_r    <= '0;
                    end
                end
                ST_STREAM: begin
                    if (g_valid_s) begin
                        cnt_r <= cnt_r + IDX_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        rr_r <= (grant_r == ID_W'(NUM_REQ-1)) ? '0 : grant_r + ID_W'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result capture: only the first engine report of a frame is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            found_r <= 1'b0;
            idx1_r  <= '0;
            idx2_r  <= '0;
        end else begin
            case (state_r)
                ST_STREAM, ST_FLUSH, ST_DRAIN: begin
                    if (eng_index_valid && !found_r) begin
                        found_r <= 1'b1;
                        idx1_r  <= eng_index1;
                        idx2_r  <= eng_index2;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        found_r <= 1'b0;
                        idx1_r  <= '0;
                        idx2_r  <= '0;
                    end
                end
                default: begin
                    found_r <= found_r;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign eng_number       = (state_r == ST_STREAM) ? g_number_s : '0;
    assign eng_number_valid = eng_valid_s;
    assign eng_number_last  = eng_last_s;
    assign eng_target       = target_r;
    assign eng_clear        = eng_clear_s;
    assign bus.resp_valid   = (state_r == ST_RESP);
    assign bus.resp_id      = grant_r;
    assign bus.resp_found   = found_r;
    assign bus.resp_index1  = idx1_r;
    assign bus.resp_index2  = idx2_r;
    assign busy             = (state_r != ST_IDLE);

endmodule
